alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 99 +++++++++
 tb/tb_alu_muldiv.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 multiply / restoring divide unit with valid/ready handshakes
module alu_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            MDop,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  Overflow,
    output logic                  DivZero
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] a_r, b_r, quo, rem, res_r, ma, mb, q_s, r_s, res_nx;
    logic [2:0] op_r;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] prod, prod_s;
    logic [W:0] sum, shl;
    logic ovf_r, dz_r, is_div, sgn, sa, sb, last, fit, div_z, ovf;
    function automatic logic sgn_of(input logic [2:0] op);
        return op[2] ? ~op[0] : (op[1:0] == 2'b01);
    endfunction
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
        return (s && x[W-1]) ? -x : x;
    endfunction
    always_comb begin
        is_div = op_r[2];
        sgn = sgn_of(op_r);
        sa = sgn & a_r[W-1];
        sb = sgn & b_r[W-1];
        ma = mag(a_r, sgn);
        mb = mag(b_r, sgn);
        last = cnt == CW'(W);
        sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, ma} : '0);
        shl = {rem, quo[W-1]};
        fit = shl >= {1'b0, mb};
        prod_s = (sa ^ sb) ? -prod : prod;
        q_s = (sa ^ sb) ? -quo : quo;
        r_s = sa ? -rem : rem;
        div_z = b_r == '0;
        ovf = is_div & ~op_r[0] & (a_r == {1'b1, {(W-1){1'b0}}}) & (&b_r);
        res_nx = !is_div ? (op_r[0] ? prod_s[2*W-1:W] : prod_s[W-1:0])
               : div_z ? (op_r[1] ? a_r : '1)
               : (op_r[1] ? r_s : q_s);
        state_nx = state == IDLE ? (in_valid ? CALC : IDLE)
                 : state == CALC ? (last ? DONE : CALC)
                 : (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk)
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            op_r <= '0;
            cnt <= '0;
            prod <= '0;
            rem <= '0;
            quo <= '0;
            res_r <= '0;
            ovf_r <= 1'b0;
            dz_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r <= A;
            b_r <= B;
            op_r <= MDop;
            cnt <= '0;
            prod <= {{W{1'b0}}, mag(B, sgn_of(MDop))};
            rem <= '0;
            quo <= mag(A, sgn_of(MDop));
        end else if (state == CALC) begin
            if (last) begin
                res_r <= res_nx;
                ovf_r <= ovf;
                dz_r <= is_div & div_z;
            end else begin
                cnt <= cnt + CW'(1);
                prod <= {sum, prod[W-1:1]};
                rem <= W'(fit ? shl - {1'b0, mb} : shl);
                quo <= {quo[W-2:0], fit};
            end
        end
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign Result = res_r;
    assign Zero = res_r == '0;
    assign Overflow = ovf_r;
    assign DivZero = dz_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table plus hold and mid-calculation reset sequences
module tb_alu_muldiv;
    localparam int W = 32;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic [2:0] MDop = '0;
    logic in_ready, out_valid, Zero, Overflow, DivZero;
    logic [W-1:0] Result;
    int ncmp = 0, nfail = 0;
    typedef struct {
        logic [W-1:0] a, b;
        logic [2:0] op;
        logic [W-1:0] res;
        logic ovf, dz;
    } vec_t;
    vec_t vecs[$];
    always #5 clk = ~clk;
    alu_muldiv #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .MDop(MDop),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero)
    );
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic add(input logic [W-1:0] a, b, input logic [2:0] op,
                       input logic [W-1:0] res, input logic ovf, dz);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res; v.ovf = ovf; v.dz = dz;
        vecs.push_back(v);
    endtask
    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        in_valid = 1'b1; A = v.a; B = v.b; MDop = v.op;
        chk($sformatf("%s ready", tag), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            A = $urandom; B = $urandom; MDop = 3'($urandom); in_valid = cyc[0];
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk($sformatf("%s latency", tag), 64'(cyc), 64'd33);
        chk($sformatf("%s result", tag), Result, v.res);
        chk($sformatf("%s zero", tag), Zero, v.res == '0);
        chk($sformatf("%s overflow", tag), Overflow, v.ovf);
        chk($sformatf("%s divzero", tag), DivZero, v.dz);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("%s back_idle", tag), in_ready, 1);
        chk($sformatf("%s valid_drop", tag), out_valid, 0);
    endtask
    initial begin
        vec_t v;
        int cyc;
        add(32'h0001_0000, 32'h0001_0000, 3'b000, 32'h0000_0000, 0, 0);
        add(32'h0001_0000, 32'h0001_0000, 3'b011, 32'h0000_0001, 0, 0);
        add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 32'h0000_0000, 0, 0);
        add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE, 0, 0);
        add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 32'h0000_0001, 0, 0);
        add(32'hFFFF_FFF9, 32'h0000_0002, 3'b100, 32'hFFFF_FFFD, 0, 0);
        add(32'hFFFF_FFF9, 32'h0000_0002, 3'b110, 32'hFFFF_FFFF, 0, 0);
        add(32'h0000_0007, 32'h0000_0002, 3'b101, 32'h0000_0003, 0, 0);
        add(32'h1234_5678, 32'h0000_0000, 3'b101, 32'hFFFF_FFFF, 0, 1);
        add(32'h1234_5678, 32'h0000_0000, 3'b111, 32'h1234_5678, 0, 1);
        add(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0000, 1, 0);
        add(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h0000_0000, 1, 0);
        add(32'h0000_0003, 32'h0000_0005, 3'b010, 32'h0000_000F, 0, 0);
        add(32'hFFFF_FFFD, 32'h0000_0005, 3'b001, 32'hFFFF_FFFF, 0, 0);
        add(32'h0000_0064, 32'h0000_0007, 3'b111, 32'h0000_0002, 0, 0);
        add(32'h0000_0064, 32'h0000_0007, 3'b101, 32'h0000_000E, 0, 0);
        add(32'h0000_0064, 32'hFFFF_FFF9, 3'b100, 32'hFFFF_FFF2, 0, 0);
        add(32'h0000_0064, 32'hFFFF_FFF9, 3'b110, 32'h0000_0002, 0, 0);
        add(32'hFFFF_FFF9, 32'h0000_0000, 3'b100, 32'hFFFF_FFFF, 0, 1);
        add(32'hFFFF_FFF9, 32'h0000_0000, 3'b110, 32'hFFFF_FFF9, 0, 1);
        add(32'h8000_0000, 32'h0000_0004, 3'b011, 32'h0000_0002, 0, 0);
        add(32'h8000_0000, 32'h0000_0004, 3'b000, 32'h0000_0000, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst result", Result, 0);
        chk("rst zero", Zero, 1);
        chk("rst overflow", Overflow, 0);
        chk("rst divzero", DivZero, 0);
        rst = 1'b0;
        foreach (vecs[i]) run_op(vecs[i], $sformatf("v%0d", i));
        in_valid = 1'b1; A = 32'h7; B = 32'h2; MDop = 3'b101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold latency", 64'(cyc), 64'd33);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            chk($sformatf("hold%0d result", k), Result, 32'h3);
            chk($sformatf("hold%0d in_ready", k), in_ready, 0);
            chk($sformatf("hold%0d out_valid", k), out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold release in_ready", in_ready, 1);
        chk("hold release out_valid", out_valid, 0);
        chk("hold release result", Result, 32'h3);
        in_valid = 1'b1; A = 32'h0000_1234; B = 32'h0000_0100; MDop = 3'b000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midcalc busy", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        chk("abort result", Result, 0);
        chk("abort zero", Zero, 1);
        v.a = 32'h0000_1234; v.b = 32'h0000_0100; v.op = 3'b000;
        v.res = 32'h0012_3400; v.ovf = 1'b0; v.dz = 1'b0;
        run_op(v, "after_abort");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
